// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial slice adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for k slices; never narrower than one bit so K = 1 still works.
  function automatic int cnt_width(input int k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational N-bit ripple adder built from a chain of full adders.
module adder_slice #(
  parameter int N = 4
) (
  output logic [N-1:0] sum,
  output logic         cout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/adder_serial_nbit.sv
// Multi-cycle add/subtract: one SLICE-bit chunk per clock through a single slice adder,
// start/done handshake, registered S/C/V with signed-overflow detection.
module adder_serial_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int K  = WIDTH / SLICE;
  localparam int CW = cnt_width(K);

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_width
    $fatal(1, "adder_serial_nbit: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             a_msb_reg, a_msb_next;
  logic             b_msb_reg, b_msb_next;
  logic             c_reg, c_next;
  logic             v_reg, v_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_upd;
  logic [WIDTH-1:0] b_eff;

  // Operands are shifted right each RUN cycle, so the active chunk is always the bottom slice.
  adder_slice #(.N(SLICE)) u_slice (
    .sum  (slice_sum),
    .cout (slice_cout),
    .a    (a_reg[SLICE-1:0]),
    .b    (b_reg[SLICE-1:0]),
    .cin  (carry_reg)
  );

  for (genvar gi = 0; gi < K; gi++) begin : g_acc
    assign acc_upd[gi*SLICE +: SLICE] = (cnt_reg == CW'(gi)) ? slice_sum
                                                              : acc_reg[gi*SLICE +: SLICE];
  end

  assign b_eff = sub ? ~B : B;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    a_msb_next = a_msb_reg;
    b_msb_next = b_msb_reg;
    c_next     = c_reg;
    v_next     = v_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          a_next     = A;
          b_next     = b_eff;
          a_msb_next = A[WIDTH-1];
          b_msb_next = b_eff[WIDTH-1];
          carry_next = sub ^ C0;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        a_next     = a_reg >> SLICE;
        b_next     = b_reg >> SLICE;
        acc_next   = acc_upd;
        carry_next = slice_cout;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == CW'(K - 1)) begin
          state_next = DONE;
          s_next     = acc_upd;
          c_next     = slice_cout;
          v_next     = (a_msb_reg == b_msb_reg) && (slice_sum[SLICE-1] != a_msb_reg);
          cnt_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      a_msb_reg <= a_msb_next;
      b_msb_reg <= b_msb_next;
      c_reg     <= c_next;
      v_reg     <= v_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign S    = s_reg;
  assign C    = c_reg;
  assign V    = v_reg;

endmodule
